// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline stage: decodes the raw instruction into register fields and a
// sign-extended immediate, then holds it with its PC in a 2-entry skid buffer
// so the execute stage can stall without losing decode work.
module id_ex_skid_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode_n,
    output logic [4:0]      rd_n,
    output logic [2:0]      funct3_n,
    output logic [4:0]      rs1_n,
    output logic [4:0]      rs2_n,
    output logic [6:0]      funct7_n,
    output logic [XLEN-1:0] imm_n,
    output logic [XLEN-1:0] pc_n
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [6:0]      funct7;
        logic [4:0]      rs2;
        logic [4:0]      rs1;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t      dec;
    entry_t      main_q;
    entry_t      skid_q;
    logic        main_vld;
    logic        skid_vld;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic        accept;
    logic        consume;

    // Immediate generation: build the 32-bit sign-extended form, then widen to XLEN
    always_comb begin
        imm32 = '0;
        unique case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            OP_STORE:
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {in_instr[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        imm64 = {{32{imm32[31]}}, imm32};
    end

    // Field slicing of the incoming instruction into the entry format
    always_comb begin
        dec        = '0;
        dec.funct7 = in_instr[31:25];
        dec.rs2    = in_instr[24:20];
        dec.rs1    = in_instr[19:15];
        dec.funct3 = in_instr[14:12];
        dec.rd     = in_instr[11:7];
        dec.opcode = in_instr[6:0];
        dec.imm    = imm64[XLEN-1:0];
        dec.pc     = in_pc;
    end

    // Skid full means main is full too; refuse input until skid drains
    assign in_ready = ~skid_vld;
    assign accept   = in_valid & in_ready;
    assign consume  = main_vld & out_ready;

    // Main/skid update: skid refills main first, otherwise input fills the free slot
    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            if (consume) begin
                main_q   <= skid_q;
                skid_vld <= 1'b0;
            end
        end else if (!main_vld || consume) begin
            main_vld <= accept;
            if (accept) main_q <= dec;
        end else if (accept) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid = main_vld;
    assign opcode_n  = main_q.opcode;
    assign rd_n      = main_q.rd;
    assign funct3_n  = main_q.funct3;
    assign rs1_n     = main_q.rs1;
    assign rs2_n     = main_q.rs2;
    assign funct7_n  = main_q.funct7;
    assign imm_n     = main_q.imm;
    assign pc_n      = main_q.pc;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg (XLEN=64): directed scenarios plus random traffic,
// scored against a depth-2 FIFO model with an arithmetic immediate decoder.
module tb_id_ex_skid_reg;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [6:0]      opcode_n;
    logic [4:0]      rd_n;
    logic [2:0]      funct3_n;
    logic [4:0]      rs1_n;
    logic [4:0]      rs2_n;
    logic [6:0]      funct7_n;
    logic [XLEN-1:0] imm_n;
    logic [XLEN-1:0] pc_n;

    id_ex_skid_reg #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .opcode_n(opcode_n), .rd_n(rd_n), .funct3_n(funct3_n),
        .rs1_n(rs1_n), .rs2_n(rs2_n), .funct7_n(funct7_n), .imm_n(imm_n), .pc_n(pc_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    fails  = 0;
    bit    run    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference immediate built from the bit weights of each format
    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        longint s = i[31] ? 1 : 0;
        longint v;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73:
                v = -s * 2048 + longint'(i[30:20]);
            7'h23:
                v = -s * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:7]);
            7'h63:
                v = -s * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                    + longint'(i[11:8]) * 2;
            7'h37, 7'h17:
                v = -s * (longint'(1) << 31) + longint'(i[30:12]) * 4096;
            7'h6f:
                v = -s * (longint'(1) << 20) + longint'(i[19:12]) * 4096
                    + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            default:
                v = 0;
        endcase
        return v;
    endfunction

    // Monitor: compare presented entry with the oldest expected one, pop on consume
    always @(negedge clk) begin
        if (run && !reset) begin
            check("in_ready", {63'b0, in_ready}, {63'b0, exp_q.size() < 2});
            check("out_valid", {63'b0, out_valid}, {63'b0, exp_q.size() != 0});
            if (out_valid && exp_q.size() != 0) begin
                check("fields", {32'b0, funct7_n, rs2_n, rs1_n, funct3_n, rd_n, opcode_n},
                      {32'b0, exp_q[0].instr});
                check("imm", imm_n, ref_imm(exp_q[0].instr));
                check("pc", pc_n, exp_q[0].pc);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus; returns late in the cycle with outputs stable
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] p,
                        input logic ordy, input logic fl);
        bit rdy;
        item_t it;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        out_ready = ordy;
        flush     = fl;
        rdy = exp_q.size() < 2;
        #8;
        if (fl) exp_q.delete();
        else if (v && rdy) begin
            it.instr = ins;
            it.pc    = p;
            exp_q.push_back(it);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #8;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #8;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_fields", {32'b0, funct7_n, rs2_n, rs1_n, funct3_n, rd_n, opcode_n}, 64'd0);
        check("rst_imm", imm_n, 64'd0);
        check("rst_pc", pc_n, 64'd0);
    endtask

    logic [31:0] rnd_ins;
    logic [6:0]  ops [10];

    initial begin
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33};
        do_reset();
        run = 1'b1;

        // stream with EX always ready
        step(1, 32'h00500113, 64'h12, 1, 0);
        step(1, 32'h00A00193, 64'h16, 1, 0);
        check("s1_rd", {59'b0, rd_n}, 64'd2);
        check("s1_rs1", {59'b0, rs1_n}, 64'd0);
        check("s1_opcode", {57'b0, opcode_n}, 64'h13);
        check("s1_funct3", {61'b0, funct3_n}, 64'd0);
        check("s1_imm", imm_n, 64'd5);
        check("s1_pc", pc_n, 64'h12);
        step(1, 32'h00002223, 64'h1A, 1, 0);
        check("s2_rd", {59'b0, rd_n}, 64'd3);
        check("s2_imm", imm_n, 64'hA);
        step(0, 32'h0, 64'h0, 1, 0);
        check("s3_opcode", {57'b0, opcode_n}, 64'h23);
        check("s3_funct3", {61'b0, funct3_n}, 64'd2);
        check("s3_rd", {59'b0, rd_n}, 64'd4);
        check("s3_imm", imm_n, 64'd4);
        check("s3_pc", pc_n, 64'h1A);
        step(0, 32'h0, 64'h0, 1, 0);

        // stall: main and skid fill, third instruction waits upstream
        step(1, 32'h00100093, 64'h100, 0, 0);
        step(1, 32'h00200113, 64'h104, 0, 0);
        step(1, 32'h00300193, 64'h108, 0, 0);
        check("stall_in_ready", {63'b0, in_ready}, 64'd0);
        check("stall_pc", pc_n, 64'h100);
        step(1, 32'h00300193, 64'h108, 1, 0);
        step(1, 32'h00300193, 64'h108, 1, 0);
        check("drain_pc2", pc_n, 64'h104);
        step(0, 32'h0, 64'h0, 1, 0);
        check("drain_pc3", pc_n, 64'h108);
        step(0, 32'h0, 64'h0, 1, 0);

        // flush with both entries full and an input presented
        step(1, 32'h00400213, 64'h200, 0, 0);
        step(1, 32'h00500293, 64'h204, 0, 0);
        step(1, 32'h00600313, 64'h208, 1, 1);
        step(0, 32'h0, 64'h0, 1, 0);
        check("flush_out_valid", {63'b0, out_valid}, 64'd0);
        check("flush_in_ready", {63'b0, in_ready}, 64'd1);

        // sign extension at XLEN=64
        step(1, 32'hFFF00093, 64'h300, 1, 0);
        step(1, 32'hFE000EE3, 64'h304, 1, 0);
        check("sext_addi", imm_n, 64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 32'h0, 64'h0, 1, 0);
        check("sext_beq", imm_n, 64'hFFFF_FFFF_FFFF_FFFC);

        // reset while stalled with both entries full
        step(1, 32'h12345037, 64'h400, 0, 0);
        step(1, 32'h0040006F, 64'h404, 0, 0);
        do_reset();

        // random valid/ready/flush traffic
        for (int n = 0; n < 10000; n++) begin
            rnd_ins = $urandom;
            if ($urandom_range(0, 3) != 0) rnd_ins[6:0] = ops[$urandom_range(0, 9)];
            step($urandom_range(0, 3) != 0, rnd_ins, {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        step(0, 32'h0, 64'h0, 1, 0);
        check("final_empty", {63'b0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_reg.md
# id_ex_skid_reg

Parametrised ID/EX pipeline stage for the RISC-V core that decodes a 32-bit instruction into its fields and sign-extended immediate, and registers them with the PC into the execute stage. It replaces the fixed, always-advancing ID/EX register with a valid/ready pipeline stage. A 2-entry skid buffer lets the execute stage stall without losing in-flight decode work, and a flush input squashes both entries on branch/jump redirect. It sits between the fetch/decode output and the EX stage.

## Interface
- XLEN, 32, width of PC and immediate outputs; legal values 32 or 64.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  decode side presents an instruction.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  squash all held entries this edge.
- out_valid  out  1  output entry valid.
- out_ready  in  1  EX stage consumes the entry.
- opcode_n  out  7  instr[6:0].
- rd_n  out  5  instr[11:7], raw for every format.
- funct3_n  out  3  instr[14:12].
- rs1_n  out  5  instr[19:15].
- rs2_n  out  5  instr[24:20].
- funct7_n  out  7  instr[31:25].
- imm_n  out  XLEN  sign-extended immediate.
- pc_n  out  XLEN  registered in_pc.

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry has a valid bit and the decoded field set: fields, imm, pc.
- Accept: in_valid & in_ready. Consume: out_valid & out_ready.
- Decode and immediate generation happen combinationally before the registers. Fields are slices of the instruction.
- Immediate by opcode:
  - I-type (0010011, 0000011, 1100111, 1110011): instr[31:20] sign-extended.
  - S-type (0100011): {instr[31:25], instr[11:7]} sign-extended.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0} sign-extended to XLEN.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
  - Any other opcode (including R-type): imm = 0.
- Transitions per edge, with flush=0:
  - Main empty or consumed, skid empty: an accepted input loads main. With no accept, main valid = 0.
  - Main full and not consumed: an accepted input loads skid (possible only when skid is empty).
  - Main consumed and skid full: skid moves to main and skid clears. in_ready is 0 this cycle, so there is no accept.
- Flush=1: main and skid valid bits clear at the edge. Any input accepted in the same cycle is discarded. out_ready is ignored.
- Reset has priority over flush. Reset zeroes every output register and both valid bits, and in_ready reads 1 after the reset edge. Reset mid-stall drops both entries.
- Data registers update only when loaded. When not loaded they hold their value; when out_valid = 0 their contents are don't-care except after reset, where they are 0.

## Timing
- Latency: 1 cycle from accept to out_valid with the decoded fields.
- Throughput: 1 instruction/cycle while out_ready = 1.
- in_ready is combinational from skid_valid only, with no path from out_ready. It drops the cycle after the skid fills and rises the cycle after the skid drains.
- Order is preserved: main is always older than skid.
- out_valid may not deassert without a consume, flush, or reset.

## Test plan
- Reset then stream: reset held 1 cycle, then 00500113 / 00A00193 / 00002223 at PC 0x12 / 0x16 / 0x1A with out_ready=1.
  - One cycle later: rd=2, rs1=0, opcode=13, funct3=0, imm=5, pc=0x12.
  - Then: rd=3, imm=0xA.
  - Then: opcode=23, funct3=2, rd=4, imm=4, pc=0x1A.
- Stall: out_ready=0 while streaming 3 instructions.
  - First sits in main, second in skid, in_ready=0, third held upstream.
  - Raise out_ready: outputs appear in order over 3 consecutive cycles with no loss or duplication.
- Flush with both entries full plus an input present:
  - Next cycle out_valid=0 and in_ready=1.
  - The flushed instructions never appear on the output.
- Immediate sign extension, XLEN=64: instr FFF00093 gives imm 0xFFFFFFFFFFFFFFFF. BEQ FE000EE3 gives imm −4 (0xFFFFFFFFFFFFFFFC).
- Reset during stall with both entries full: the next cycle shows all outputs 0 and out_valid=0.
- Randomized valid/ready/flush against a scoreboard for 10k cycles: no drop, reorder, or duplicate, and in_ready equals NOT skid_valid every cycle.
